// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants for the performance counter bank
package perf_pkg;

  localparam int DEF_NUM_CH = 6;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_ADDR_W = 5;

  // The cycle counter sits directly after the last event channel in the read map.
  localparam int CYCLE_IDX_OFS = 0;

  localparam int CH_RETIRE = 0;
  localparam int CH_IC_REQ = 1;
  localparam int CH_IC_HIT = 2;
  localparam int CH_DC_REQ = 3;
  localparam int CH_DC_HIT = 4;
  localparam int CH_STALL  = 5;

  function automatic int cycleIdx(input int numCh);
    return numCh + CYCLE_IDX_OFS;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - registered single-port read bus of the counter bank
interface perf_counter_bank_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_err;

  modport master (
    output rd_req, rd_addr,
    input  rd_valid, rd_data, rd_err
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_valid, rd_data, rd_err
  );

endinterface

// File: rtl/perf_event_counter.sv
// rtl/perf_event_counter.sv - one wrapping or saturating counter with sticky overflow flag
module perf_event_counter #(
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic atMax;

  assign atMax = &value;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (atMax) begin
        ovf <= 1'b1;
        if (SAT_MODE == 0) value <= '0;
      end else begin
        value <= value + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - event and cycle counters with halt freeze and registered reads
// Optional PERF_SNAPSHOT_EN adds a snap input and shadow registers that reads return.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SAT_MODE = 0,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_en,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              halt,
  input  logic              clr,
`ifdef PERF_SNAPSHOT_EN
  input  logic              snap,
`endif
  output logic [NUM_CH:0]   overflow,
  output logic              frozen,
  perf_counter_bank_if.slave rdBus
);

  localparam int NUM_CNT = cycleIdx(NUM_CH) + 1;

  logic               cntEn;
  logic [NUM_CNT-1:0] incVec;
  logic [CNT_W-1:0]   cntVal [NUM_CNT];
  logic [CNT_W-1:0]   srcVal [NUM_CNT];
  logic [CNT_W-1:0]   rdMux;
  logic               addrBad;

  assign cntEn  = count_en & ~frozen;
  assign incVec = {cntEn, event_i & {NUM_CH{cntEn}}};

  for (genvar i = 0; i < NUM_CNT; i++) begin : gCnt
    perf_event_counter #(
      .CNT_W   (CNT_W),
      .SAT_MODE(SAT_MODE)
    ) uCnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (incVec[i]),
      .value(cntVal[i]),
      .ovf  (overflow[i])
    );
  end

  // The halt cycle itself still counts because cntEn uses the registered flag.
  always_ff @(posedge clk) begin
    if (rst || clr) frozen <= 1'b0;
    else if (halt)  frozen <= 1'b1;
  end

`ifdef PERF_SNAPSHOT_EN
  logic             takeSnap;
  logic [CNT_W-1:0] nextVal [NUM_CNT];

  assign takeSnap = snap | (halt & ~frozen);

  // Shadows capture post-update values, so mirror the counter's next state here.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      nextVal[i] = cntVal[i];
      if (incVec[i]) begin
        if (&cntVal[i]) nextVal[i] = (SAT_MODE != 0) ? cntVal[i] : '0;
        else            nextVal[i] = cntVal[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rst || clr)    srcVal[i] <= '0;
      else if (takeSnap) srcVal[i] <= nextVal[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) srcVal[i] = cntVal[i];
  end
`endif

  // Unmatched addresses fall through to zero, which is the out-of-range data.
  always_comb begin
    rdMux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rdBus.rd_addr == ADDR_W'(i)) rdMux = srcVal[i];
    end
  end

  assign addrBad = rdBus.rd_addr > ADDR_W'(cycleIdx(NUM_CH));

  always_ff @(posedge clk) begin
    if (rst) begin
      rdBus.rd_valid <= 1'b0;
      rdBus.rd_data  <= '0;
      rdBus.rd_err   <= 1'b0;
    end else begin
      rdBus.rd_valid <= rdBus.rd_req;
      if (rdBus.rd_req) begin
        rdBus.rd_data <= rdMux;
        rdBus.rd_err  <= addrBad;
      end
    end
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Synthesizable performance-monitor block that replaces bench-only instruction and cache-event counting. It holds NUM_CH parameterised event counters plus a free-running cycle counter, and freezes all counting when the processor halts. Counters are readable through a registered single-port read interface. It sits beside the processor core and takes 1-bit event strobes: retire, icache req/hit, dcache req/hit, stall.

Parameters:
NUM_CH, 6, number of event channels (1..16).
CNT_W, 32, counter width in bits (8..64).
SAT_MODE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters saturate at all-ones.
ADDR_W, 5, read address width; must satisfy 2^ADDR_W >= NUM_CH+1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
count_en  in  1  global count enable
event_i  in  NUM_CH  per-channel event strobes, one count per cycle when high
halt  in  1  processor halt indication
clr  in  1  synchronous clear of all counters, overflow flags and freeze
rd_req  in  1  read request
rd_addr  in  ADDR_W  0..NUM_CH-1 = event channels; NUM_CH = cycle counter
rd_valid  out  1  read data valid, one-cycle pulse
rd_data  out  CNT_W  read data
rd_err  out  1  qualifies rd_valid; address out of range
overflow  out  NUM_CH+1  sticky per-counter overflow flags; MSB = cycle counter
frozen  out  1  counting stopped by halt

Behaviour:
- Reset (rst=1 at a clk edge): all counters 0, overflow 0, frozen 0, rd_valid 0, rd_data 0, rd_err 0. Reset overrides every other input, including mid-read; a read pending at reset is dropped.
- Increment condition, channel i: event_i[i] & count_en & ~frozen. Cycle counter: count_en & ~frozen.
- Halt: the cycle in which halt=1 is sampled is still counted. frozen becomes 1 on that edge and stays 1 until clr or rst; further halt pulses are ignored.
- clr: on the edge where clr=1, all counters, overflow flags and frozen go to 0. clr beats a simultaneous event, so the counter is 0 after that edge, not 1. clr beats a simultaneous halt, so frozen=0.
- Wrap mode (SAT_MODE=0): all-ones + 1 gives 0, and overflow[i] is set (sticky).
- Saturate mode (SAT_MODE=1): the counter holds at all-ones. overflow[i] is set on the first attempted increment past all-ones.
- Read:
  - rd_req at edge N gives rd_valid=1 at edge N+1, with rd_data holding the counter value before any increment at edge N.
  - rd_addr > NUM_CH: rd_data=0, rd_err=1.
  - Back-to-back reads are allowed, one per cycle. rd_valid is 0 in any cycle with no request in the prior cycle, and rd_data then holds its last value.
- Reads never disturb counting. A read and a clr at the same edge returns the pre-clear value.

Optional Feature:
- Macro: PERF_SNAPSHOT_EN.
- Defined:
  - Adds input snap (1 bit) and a shadow register per counter, including the cycle counter.
  - On an edge with snap=1, shadows capture the counter values as they are after that edge's update.
  - halt entering frozen also takes a snapshot automatically.
  - Reads return shadow values, not live ones.
  - clr zeroes the shadows. snap with clr at the same edge gives shadows of 0.
- Not defined: no snap port, no shadow storage, reads return live counters.

Decomposition:
- Package perf_pkg holds:
  - localparam CYCLE_IDX offset convention (cycle counter at address NUM_CH);
  - default widths;
  - channel index constants CH_RETIRE=0, CH_IC_REQ=1, CH_IC_HIT=2, CH_DC_REQ=3, CH_DC_HIT=4, CH_STALL=5.
- Sub-module perf_event_counter (params CNT_W, SAT_MODE; ports clk, rst, clr, inc, value, ovf) is instantiated NUM_CH+1 times.
- The top level holds the freeze flag, the read mux/register and the optional snapshot.

Test Plan:
1. Reset then count_en=1, event_i[0] high for 10 cycles, rd_addr=0 -> rd_valid next cycle, rd_data=10, rd_err=0.
2. Freeze: event_i[2] high continuously, halt pulses at cycle 5 after reset release -> channel 2 reads 5 (halt cycle counted) and frozen=1. A further 20 cycles leaves it at 5. clr -> reads 0, frozen=0.
3. Wrap: CNT_W=8, SAT_MODE=0, 257 events -> value 1, overflow[0]=1. Saturate: SAT_MODE=1, 300 events -> value 255, overflow[0]=1.
4. Simultaneous clr with event_i[1] and with rd_req on addr 1 (value 7) -> returned rd_data=7, counter value 0 afterwards.
5. rd_addr=NUM_CH+3 -> rd_valid=1, rd_err=1, rd_data=0. Three back-to-back reads on addrs 0, 1, NUM_CH -> three consecutive rd_valid pulses with correct values; addr NUM_CH equals the elapsed enabled cycles.
6. With PERF_SNAPSHOT_EN: snap at count 4, then 6 more events -> read returns 4. rst asserted mid-read -> rd_valid=0 next cycle, all reads return 0.
